// File: rtl/lives_decrement_ctrl_if.sv
// Signal bundle between the lives control stage and its neighbours: the game
// control unit (start, invuln, game_over), the collision detector (hit) and
// the lives decrementer (ld, D, ent, enp, rco).
//   master : the control stage (drives ld/D/ent/enp/invuln/game_over)
//   slave  : the environment (drives start/hit/rco)
interface lives_decrement_ctrl_if;
  logic       start;
  logic       hit;
  logic       rco;
  logic       ld;
  logic [3:0] D;
  logic       ent;
  logic       enp;
  logic       invuln;
  logic       game_over;

  modport master (
    input  start, hit, rco,
    output ld, D, ent, enp, invuln, game_over
  );

  modport slave (
    output start, hit, rco,
    input  ld, D, ent, enp, invuln, game_over
  );
endinterface

// File: rtl/lives_decrement_ctrl.sv
// Lives decrement control stage. Turns ship-collision levels into one-cycle
// decrement enables, loads the starting lives count, holds an invulnerability
// window after every hit and raises game_over once the decrementer reports 0.
// Ports:
//   clock     : system clock, rising edge
//   reset     : synchronous active-high reset
//   bus       : master side of lives_decrement_ctrl_if
//     start (in)  new-game request, honoured in IDLE / GAME_OVER only
//     hit   (in)  collision level, synchronous to clock
//     rco   (in)  decrementer rco (lives == 0 with ent high)
//     ld    (out) decrementer load pulse
//     D     (out) decrementer load data, constant LIVES_INIT
//     ent   (out) decrementer ent level
//     enp   (out) decrementer enp pulse, one per accepted hit
//     invuln(out) high during the invulnerability window
//     game_over (out) high while in GAME_OVER
// INVULN_CYCLES must be at least 1.
module lives_decrement_ctrl #(
  parameter logic [3:0]  LIVES_INIT    = 4'd3,
  parameter int unsigned INVULN_CYCLES = 100,
  parameter int unsigned TIMER_W       = $clog2(INVULN_CYCLES + 1)
) (
  input logic                    clock,
  input logic                    reset,
  lives_decrement_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StArmed,
    StDec,
    StCheck,
    StInvuln,
    StGameOver
  } state_e;

  state_e             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               hit_q;
  logic               hit_acc;

  logic ld, ent, enp, invuln, game_over;

  // Only a rising edge of the collision level counts; a held level never retriggers.
  assign hit_acc = bus.hit & ~hit_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      timer_q <= '0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      hit_q   <= bus.hit;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) state_d = StLoad;
      end
      StLoad: begin
        state_d = StArmed;
      end
      StArmed: begin
        // rco first: also covers a zero starting lives count.
        if (bus.rco) begin
          state_d = StGameOver;
        end else if (hit_acc) begin
          state_d = StDec;
        end
      end
      StDec: begin
        state_d = StCheck;
      end
      StCheck: begin
        // One settle cycle after enp so rco reflects the decremented count.
        if (bus.rco) begin
          state_d = StGameOver;
        end else begin
          state_d = StInvuln;
          timer_d = TIMER_W'(INVULN_CYCLES - 1);
        end
      end
      StInvuln: begin
        if (timer_q == '0) begin
          state_d = StArmed;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      StGameOver: begin
        if (bus.start) state_d = StLoad;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Moore outputs: pure decodes of the state register.
  always_comb begin
    ld        = 1'b0;
    ent       = 1'b0;
    enp       = 1'b0;
    invuln    = 1'b0;
    game_over = 1'b0;
    unique case (state_q)
      StIdle: ;
      StLoad: begin
        ld  = 1'b1;
        ent = 1'b1;
      end
      StArmed: ent = 1'b1;
      StDec: begin
        ent = 1'b1;
        enp = 1'b1;
      end
      StCheck: ent = 1'b1;
      StInvuln: begin
        ent    = 1'b1;
        invuln = 1'b1;
      end
      StGameOver: begin
        ent       = 1'b1;
        game_over = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.ld        = ld;
  assign bus.D         = LIVES_INIT;
  assign bus.ent       = ent;
  assign bus.enp       = enp;
  assign bus.invuln    = invuln;
  assign bus.game_over = game_over;

endmodule
